// File: rtl/tag_pkg.sv
// Shared constants, entry layout and FSM encoding for the tag lookup controller.
package tag_pkg;
  localparam int NSETS   = 64;
  localparam int NWAYS   = 4;
  localparam int TAGW    = 20;
  localparam int STW     = 2;
  localparam int ENTW    = TAGW + STW;
  localparam int IDXW    = $clog2(NSETS);
  localparam int WAYW    = $clog2(NWAYS);
  localparam int TAG_LSB = 12;
  localparam int IDX_LSB = 6;

  localparam logic [STW-1:0] ST_INVALID = 2'b00;

  typedef enum logic {
    S_FLUSH = 1'b0,
    S_READY = 1'b1
  } fsm_e;

  typedef struct packed {
    logic [STW-1:0]  st;
    logic [TAGW-1:0] tag;
  } entry_t;

  function automatic logic [NWAYS-1:0] way_onehot(input logic [WAYW-1:0] w);
    way_onehot    = '0;
    way_onehot[w] = 1'b1;
  endfunction
endpackage

// File: rtl/tag_way_select.sv
// Combinational 4-way tag compare plus victim choice (first invalid way, else round-robin).
module tag_way_select
  import tag_pkg::*;
(
  input  entry_t [NWAYS-1:0] ent_i,
  input  logic [TAGW-1:0]    tag_i,
  input  logic [WAYW-1:0]    rr_i,
  output logic [NWAYS-1:0]   hit_vec_o,
  output logic               hit_o,
  output logic [WAYW-1:0]    way_o,
  output logic [STW-1:0]     state_o,
  output logic [WAYW-1:0]    victim_o,
  output logic               all_valid_o
);
  logic [NWAYS-1:0] hv;
  logic [NWAYS-1:0] inv;

  always_comb begin
    hv        = '0;
    inv       = '0;
    way_o     = '0;
    state_o   = ST_INVALID;
    victim_o  = rr_i;
    // Walk downward so the lowest-indexed match wins.
    for (int w = NWAYS-1; w >= 0; w--) begin
      inv[w] = (ent_i[w].st == ST_INVALID);
      hv[w]  = !inv[w] && (ent_i[w].tag == tag_i);
      if (hv[w]) begin
        way_o   = WAYW'(w);
        state_o = ent_i[w].st;
      end
      if (inv[w]) victim_o = WAYW'(w);
    end
  end

  assign hit_vec_o   = hv;
  assign hit_o       = |hv;
  assign all_valid_o = ~|inv;
endmodule

// File: rtl/tag_lookup_ctrl.sv
// Owns the tag SRAM RW port: invalidation walk, write-priority arbitration, 1-cycle lookup response.
module tag_lookup_ctrl
  import tag_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAYW-1:0]   resp_way,
  output logic [STW-1:0]    resp_state,
  output logic [WAYW-1:0]   resp_victim,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDXW-1:0]   wr_idx,
  input  logic [WAYW-1:0]   wr_way,
  input  logic [STW-1:0]    wr_state,
  input  logic [TAGW-1:0]   wr_tag,
  input  logic              flush_req,
  output logic              busy,
  output logic [IDXW-1:0]   ta_addr,
  output logic              ta_en,
  output logic              ta_wmode,
  output logic [ENTW-1:0]   ta_wdata,
  output logic [NWAYS-1:0]  ta_wmask,
  input  logic [ENTW-1:0]   ta_rdata_0,
  input  logic [ENTW-1:0]   ta_rdata_1,
  input  logic [ENTW-1:0]   ta_rdata_2,
  input  logic [ENTW-1:0]   ta_rdata_3
);
  fsm_e            state_q, state_d;
  logic [IDXW-1:0] flush_idx_q, flush_idx_d;
  logic [WAYW-1:0] rr_q, rr_d;
  logic            s1_valid_q;
  logic [TAGW-1:0] s1_tag_q;

  logic            is_ready, wr_go, rd_go;
  entry_t [NWAYS-1:0] ents;
  logic [NWAYS-1:0] hit_vec;
  logic            hit, all_valid;
  logic [WAYW-1:0] hit_way, victim;
  logic [STW-1:0]  hit_st;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^req_addr[IDX_LSB-1:0];

  assign is_ready  = (state_q == S_READY);
  assign busy      = !is_ready;
  assign wr_ready  = is_ready;
  assign req_ready = is_ready && !wr_valid;
  assign wr_go     = is_ready && wr_valid;
  assign rd_go     = req_ready && req_valid;

  always_comb begin
    ta_en    = 1'b0;
    ta_wmode = 1'b0;
    ta_addr  = '0;
    ta_wdata = '0;
    ta_wmask = '0;
    if (!is_ready) begin
      ta_en    = 1'b1;
      ta_wmode = 1'b1;
      ta_addr  = flush_idx_q;
      ta_wmask = '1;
    end else if (wr_go) begin
      ta_en    = 1'b1;
      ta_wmode = 1'b1;
      ta_addr  = wr_idx;
      ta_wdata = {wr_state, wr_tag};
      ta_wmask = way_onehot(wr_way);
    end else if (rd_go) begin
      ta_en    = 1'b1;
      ta_addr  = req_addr[IDX_LSB +: IDXW];
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    if (!is_ready) begin
      flush_idx_d = flush_idx_q + IDXW'(1);
      if (flush_idx_q == IDXW'(NSETS-1)) state_d = S_READY;
    end else if (flush_req) begin
      state_d     = S_FLUSH;
      flush_idx_d = '0;
    end
  end

  // Round-robin only advances when a miss found no invalid way to take.
  assign rr_d = (s1_valid_q && !hit && all_valid) ? rr_q + WAYW'(1) : rr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_FLUSH;
      flush_idx_q <= '0;
      rr_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
      rr_q        <= rr_d;
      s1_valid_q  <= rd_go;
      if (rd_go) s1_tag_q <= req_addr[TAG_LSB +: TAGW];
    end
  end

  assign ents[0] = ta_rdata_0;
  assign ents[1] = ta_rdata_1;
  assign ents[2] = ta_rdata_2;
  assign ents[3] = ta_rdata_3;

  tag_way_select u_sel (
    .ent_i       (ents),
    .tag_i       (s1_tag_q),
    .rr_i        (rr_q),
    .hit_vec_o   (hit_vec),
    .hit_o       (hit),
    .way_o       (hit_way),
    .state_o     (hit_st),
    .victim_o    (victim),
    .all_valid_o (all_valid)
  );

  assign resp_valid  = s1_valid_q;
  assign resp_hit    = s1_valid_q && hit;
  assign resp_way    = s1_valid_q ? hit_way : '0;
  assign resp_state  = s1_valid_q ? hit_st  : ST_INVALID;
  assign resp_victim = s1_valid_q ? victim  : '0;

  a_single_hit: assert property (@(posedge clock) disable iff (reset)
    s1_valid_q |-> $onehot0(hit_vec));
endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed + random bench for tag_lookup_ctrl with an SRAM model and a set/way reference model.
module tb_tag_lookup_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready, resp_valid, resp_hit;
  logic [31:0] req_addr;
  logic [1:0]  resp_way, resp_state, resp_victim;
  logic        wr_valid, wr_ready, flush_req, busy;
  logic [5:0]  wr_idx, ta_addr;
  logic [1:0]  wr_way, wr_state;
  logic [19:0] wr_tag;
  logic        ta_en, ta_wmode;
  logic [21:0] ta_wdata;
  logic [3:0]  ta_wmask;
  logic [21:0] rd [4];

  always #5 clock = ~clock;

  tag_lookup_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_state(resp_state), .resp_victim(resp_victim),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_way(wr_way),
    .wr_state(wr_state), .wr_tag(wr_tag),
    .flush_req(flush_req), .busy(busy),
    .ta_addr(ta_addr), .ta_en(ta_en), .ta_wmode(ta_wmode),
    .ta_wdata(ta_wdata), .ta_wmask(ta_wmask),
    .ta_rdata_0(rd[0]), .ta_rdata_1(rd[1]), .ta_rdata_2(rd[2]), .ta_rdata_3(rd[3])
  );

  // Tag SRAM: one RW port, masked writes, read data registered.
  logic [21:0] mem [64][4];
  always @(posedge clock) begin
    if (ta_en) begin
      if (ta_wmode) begin
        for (int w = 0; w < 4; w++) if (ta_wmask[w]) mem[ta_addr][w] <= ta_wdata;
      end else begin
        for (int w = 0; w < 4; w++) rd[w] <= mem[ta_addr][w];
      end
    end
  end

  // Reference model state
  int ref_st  [64][4];
  int ref_tag [64][4];
  int rr_m, fl_left;
  bit pend;
  int e_hit, e_way, e_st, e_vic;
  int vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic clear_ref();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++) begin ref_st[s][w] = 0; ref_tag[s][w] = 0; end
  endtask

  task automatic predict(input logic [31:0] a);
    int idx, t;
    idx = int'(a[11:6]); t = int'(a[31:12]);
    e_hit = 0; e_way = 0; e_st = 0; e_vic = -1;
    for (int w = 0; w < 4; w++)
      if (e_hit == 0 && ref_st[idx][w] != 0 && ref_tag[idx][w] == t) begin
        e_hit = 1; e_way = w; e_st = ref_st[idx][w];
      end
    for (int w = 0; w < 4; w++) if (e_vic < 0 && ref_st[idx][w] == 0) e_vic = w;
    if (e_hit == 0 && e_vic < 0) begin e_vic = rr_m; rr_m = (rr_m + 1) % 4; end
  endtask

  task automatic step(input bit wv, input int widx, input int wway, input int wst,
                      input int wtag, input bit rv, input logic [31:0] ra, input bit fl);
    bit rdy;
    logic [21:0] wd;
    @(negedge clock);
    chk("resp_valid", 32'(resp_valid), 32'(pend));
    if (pend) begin
      chk("resp_hit", 32'(resp_hit), 32'(e_hit));
      if (e_hit != 0) begin
        chk("resp_way", 32'(resp_way), 32'(e_way));
        chk("resp_state", 32'(resp_state), 32'(e_st));
      end else begin
        chk("resp_victim", 32'(resp_victim), 32'(e_vic));
      end
    end
    pend = 0;
    wr_valid = wv; wr_idx = 6'(widx); wr_way = 2'(wway); wr_state = 2'(wst); wr_tag = 20'(wtag);
    req_valid = rv; req_addr = ra; flush_req = fl;
    wd = {2'(wst), 20'(wtag)};
    #1;
    rdy = (fl_left == 0);
    chk("busy", 32'(busy), 32'(!rdy));
    chk("wr_ready", 32'(wr_ready), 32'(rdy));
    chk("req_ready", 32'(req_ready), 32'(rdy && !wv));
    if (!rdy) begin
      chk("flush_en", {30'b0, ta_en, ta_wmode}, 32'h3);
      chk("flush_addr", 32'(ta_addr), 32'(64 - fl_left));
      chk("flush_mask", 32'(ta_wmask), 32'hF);
      chk("flush_data", 32'(ta_wdata), 32'h0);
    end else if (wv) begin
      chk("wr_en", {30'b0, ta_en, ta_wmode}, 32'h3);
      chk("wr_addr", 32'(ta_addr), 32'(widx));
      chk("wr_mask", 32'(ta_wmask), 32'(1 << wway));
      chk("wr_data", 32'(ta_wdata), 32'(wd));
      ref_st[widx][wway] = wst; ref_tag[widx][wway] = wtag;
    end else if (rv) begin
      chk("rd_en", {30'b0, ta_en, ta_wmode}, 32'h2);
      chk("rd_addr", 32'(ta_addr), 32'(ra[11:6]));
      predict(ra);
      pend = 1;
    end else begin
      chk("idle_en", 32'(ta_en), 32'h0);
    end
    @(posedge clock);
    if (!rdy) fl_left--;
    else if (fl) begin fl_left = 64; clear_ref(); end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic wr(input int idx, input int way, input int st, input int tag);
    step(1, idx, way, st, tag, 0, 32'h0, 0);
  endtask

  task automatic rd_req(input logic [31:0] a, input bit fl);
    step(0, 0, 0, 0, 0, 1, a, fl);
  endtask

  // Synchronous reset for one edge; rv drives a lookup that the reset must swallow.
  task automatic do_reset(input bit rv);
    @(negedge clock);
    reset = 1'b1; wr_valid = 0; flush_req = 0; req_valid = rv; req_addr = 32'h0;
    @(posedge clock);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    reset = 1'b0; req_valid = 0;
    pend = 0; fl_left = 64; rr_m = 0; clear_ref();
  endtask

  initial begin
    logic [31:0] a;
    int r, s, w, k, st, dup;
    req_valid = 0; req_addr = 0; wr_valid = 0; wr_idx = 0; wr_way = 0;
    wr_state = 0; wr_tag = 0; flush_req = 0;
    pend = 0; rr_m = 0; fl_left = 64; clear_ref();
    repeat (2) @(posedge clock);
    do_reset(0);

    // Walk with a lookup held pending; it is accepted in cycle 65.
    for (int i = 0; i < 64; i++) rd_req(32'h0, 0);
    rd_req(32'h0, 0);

    wr(5, 2, 1, 20'hABCDE);
    rd_req(32'hABCDE140, 0);
    rd_req(32'h12345140, 0);

    for (int i = 0; i < 4; i++) wr(7, i, 1 + i % 3, 20'h07000 + i);
    for (int i = 0; i < 5; i++) rd_req({20'h55500 + 20'(i), 6'd7, 6'd0}, 0);

    // Write and lookup together: write wins, lookup goes next cycle and sees the write.
    step(1, 9, 0, 3, 20'hAAAAA, 1, {20'hAAAAA, 6'd9, 6'd3}, 0);
    rd_req({20'hAAAAA, 6'd9, 6'd3}, 0);
    idle();

    // Flush with a same-cycle hitting lookup; flush_req during the walk is ignored.
    rd_req(32'hABCDE140, 1);
    for (int i = 0; i < 64; i++) step(0, 0, 0, 0, 0, 1, 32'hABCDE140, (i == 20));
    rd_req(32'hABCDE140, 0);
    idle();

    // Reset at flush_idx 30 restarts the walk from 0.
    step(0, 0, 0, 0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 30; i++) idle();
    do_reset(0);
    for (int i = 0; i < 64; i++) idle();

    // Lookup presented alongside reset is dropped.
    wr(3, 1, 2, 20'h00042);
    idle();
    do_reset(1);
    for (int i = 0; i < 64; i++) idle();

    // Random traffic over a few sets and a small tag pool.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      s = int'($urandom_range(0, 3));
      k = int'($urandom_range(0, 5));
      if (fl_left != 0 || r < 30) begin
        w = int'($urandom_range(0, 3));
        st = int'($urandom_range(0, 3));
        dup = 0;
        for (int v = 0; v < 4; v++)
          if (v != w && ref_st[s][v] != 0 && ref_tag[s][v] == 20'h10000 + k) dup = 1;
        if (dup != 0) st = 0;
        if (fl_left != 0) idle();
        else wr(s, w, st, 20'h10000 + k);
      end else if (r < 85) begin
        a = {20'h10000 + 20'(k), 6'(s), 6'($urandom_range(0, 63))};
        rd_req(a, 0);
      end else if (r == 99) begin
        step(0, 0, 0, 0, 0, 0, 32'h0, 1);
      end else begin
        idle();
      end
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tag_lookup_ctrl.md
Name: tag_lookup_ctrl

Overview:
- Controller directly upstream of the 4-way, 64-set, 22-bit tag_array SRAM wrapper.
- Owns the SRAM single RW port. Sequences the post-reset/flush invalidation walk, arbitrates refill writes against lookups, and compares the four returned ways one cycle after each read.
- Produces hit, hit-way, coherence state and a victim way for the miss handler.
- Tag entry format: {state[1:0], tag[19:0]}. state 2'b00 = invalid.
- Address split: tag = addr[31:12], index = addr[11:6], offset = addr[5:0].

Parameters:
- NSETS, 64, number of sets; index width = log2(NSETS) = 6.
- NWAYS, 4, associativity; way width = 2.
- TAGW, 20, stored tag bits.
- STW, 2, coherence state bits; entry width = TAGW+STW = 22.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  lookup accepted when req_valid & req_ready.
- req_addr  in  32  physical address of lookup.
- resp_valid  out  1  lookup result valid; one pulse per accepted request.
- resp_hit  out  1  some way matches with state != 0.
- resp_way  out  2  hitting way (0 on miss).
- resp_state  out  2  state of hitting way (0 on miss).
- resp_victim  out  2  replacement way (valid on miss).
- wr_valid  in  1  refill/state-update write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_idx  in  6  set index to write.
- wr_way  in  2  way to write.
- wr_state  in  2  new state.
- wr_tag  in  20  new tag.
- flush_req  in  1  request full invalidation.
- busy  out  1  high while flushing.
- ta_addr  out  6  to tag_array RW0_addr.
- ta_en  out  1  to RW0_en.
- ta_wmode  out  1  to RW0_wmode.
- ta_wdata  out  22  broadcast to RW0_wdata_0..3.
- ta_wmask  out  4  to RW0_wmask_3..0 ({3,2,1,0}).
- ta_rdata_0..3  in  22 each  from RW0_rdata_0..3.

Behaviour:
- FSM states: FLUSH, READY.
- Reset values: state = FLUSH, flush_idx = 0, rr_ctr = 0, resp_valid = 0, resp_* = 0. req_ready, wr_ready and ta_en are combinational from state.
- FLUSH:
  - Each cycle: ta_en = 1, ta_wmode = 1, ta_addr = flush_idx, ta_wdata = 0, ta_wmask = 4'hF.
  - flush_idx increments each cycle; at 63 the next state is READY.
  - Total 64 cycles. busy = 1, req_ready = 0, wr_ready = 0.
- READY, port arbitration (write has priority):
  - wr_valid = 1: wr_ready = 1, req_ready = 0. Drive ta_en = 1, ta_wmode = 1, ta_addr = wr_idx, ta_wdata = {wr_state, wr_tag}, ta_wmask = one-hot(wr_way).
  - Otherwise req_ready = 1. If req_valid: ta_en = 1, ta_wmode = 0, ta_addr = req_addr[11:6]. The s1 register captures req_addr[31:12] and s1_valid = 1.
- Response stage:
  - Latency is exactly 1 cycle: resp_valid = s1_valid in the cycle after acceptance.
  - Per-way compare: hit_i = (rdata_i[21:20] != 0) && (rdata_i[19:0] == s1_tag).
  - resp_hit = OR of hit_i. resp_way = lowest-indexed hitting way. resp_state = that way's state.
  - More than one hit_i set is illegal; flag it with a simulation assertion.
- Victim selection:
  - If any way is invalid, resp_victim = lowest-indexed invalid way.
  - Otherwise resp_victim = rr_ctr.
  - rr_ctr increments (wraps 3 -> 0) only on a response with resp_hit = 0 and all ways valid.
- Back-to-back lookups: throughput is 1 per cycle.
- A write in cycle T+1 does not affect the response for a read issued in cycle T (the data was already sampled).
- Write then read of the same set: the read issued after the write observes the new entry (SRAM write-first not required).
- flush_req in READY:
  - Next state is FLUSH with flush_idx = 0.
  - A lookup or write accepted in that same cycle completes normally, and its response is still delivered.
  - flush_req during FLUSH is ignored (the walk does not restart).
- Reset mid-flush or mid-lookup: synchronously returns to reset values. A pending s1 response is dropped (resp_valid = 0 next cycle).
- ta_en = 0 whenever no operation is issued.

Decomposition:
- Shared package tag_pkg holds:
  - constants TAG_LSB = 12, IDX_LSB = 6, TAGW, STW, NWAYS, NSETS;
  - state encodings ST_INVALID = 2'b00 (others opaque to this block);
  - FSM encoding.
- One sub-module, tag_way_select: purely combinational. Takes 4 entries plus the compare tag plus rr_ctr; outputs hit, way, state, victim.

Test Plan:
- Reset, then hold req_valid = 1 -> busy = 1 and 64 consecutive writes with ta_addr = 0..63, ta_wmask = 4'hF, ta_wdata = 0. req_ready rises in cycle 65.
- Write idx = 5, way = 2, state = 2'b01, tag = 20'hABCDE; then lookup addr 32'hABCDE140 -> one cycle later resp_hit = 1, resp_way = 2, resp_state = 1.
- Lookup a tag not present in set 5 (way 2 valid) -> resp_hit = 0, resp_victim = 0 (lowest invalid way).
- Fill all 4 ways of set 7, then issue 5 missing lookups -> resp_victim = 0, 1, 2, 3, 0.
- wr_valid and req_valid asserted together -> wr_ready = 1, req_ready = 0, ta_wmode = 1. The lookup is accepted the following cycle, and its response is 1 cycle after that.
- flush_req with a same-cycle lookup that hits -> the hit response is still delivered, then 64 flush cycles follow. A repeat lookup then gives resp_hit = 0. Asserting reset at flush_idx = 30 restarts the walk at 0.
